// File: rtl/demux8_shift_collector.sv
// ---------------------------------------------------------------------------
// demux8_shift_collector
//
// Serial-to-parallel collector. A serial bit stream is steered by a 3-bit
// select (j2 = weight 1, j1 = weight 2, j0 = weight 4) into one of eight
// per-lane shift registers. The lane numbering matches mux8, so a lane
// written here is read back through a mux8 using the same select values.
// Once a lane holds DEPTH bits it is presented as a parallel word on a
// valid/ready output port and then cleared.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset      - synchronous, active-high reset
//   in_bit     - serial data bit
//   in_valid   - in_bit is valid this cycle
//   j2,j1,j0   - lane select, lane = 4*j0 + 2*j1 + j2
//   in_ready   - selected lane can accept a bit (combinational)
//   out_word   - completed lane word, first received bit in the MSB
//   out_lane   - index of the lane that produced out_word
//   out_valid  - out_word/out_lane valid
//   out_ready  - consumer accepts out_word this cycle
//   err        - sticky overflow flag (write attempted to a full lane)
// ---------------------------------------------------------------------------
module demux8_shift_collector #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             j2,
    input  logic             j1,
    input  logic             j0,
    output logic             in_ready,
    output logic [DEPTH-1:0] out_word,
    output logic [2:0]       out_lane,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0] sr_q  [8];
    logic [DEPTH-1:0] sr_d  [8];
    logic [CW-1:0]    cnt_q [8];
    logic [CW-1:0]    cnt_d [8];

    logic [DEPTH-1:0] word_q, word_d;
    logic [2:0]       lane_q, lane_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [2:0]       sel;
    logic             accept;
    logic             overflow;
    logic             slot_free;
    logic             any_full;
    logic [2:0]       full_idx;

    // j2 is the LSB so the numbering lines up with the mux8 read path.
    assign sel       = {j0, j1, j2};
    assign in_ready  = (cnt_q[sel] != FULL_CNT);
    assign accept    = in_valid && in_ready;
    assign overflow  = in_valid && !in_ready;
    assign slot_free = !valid_q || out_ready;

    // Lowest-index full lane wins: scanning downward lets the last hit,
    // i.e. the smallest index, overwrite any higher one.
    always_comb begin
        any_full = 1'b0;
        full_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cnt_q[i] == FULL_CNT) begin
                any_full = 1'b1;
                full_idx = 3'(i);
            end
        end
    end

    // A draining lane is always full, so it can never be the lane being
    // written in the same cycle; both updates can be applied independently.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sr_d[i]  = sr_q[i];
            cnt_d[i] = cnt_q[i];
        end
        word_d  = word_q;
        lane_d  = lane_q;
        valid_d = valid_q;
        err_d   = err_q | overflow;

        if (accept) begin
            sr_d[sel]  = {sr_q[sel][DEPTH-2:0], in_bit};
            cnt_d[sel] = cnt_q[sel] + CW'(1);
        end

        if (slot_free) begin
            if (any_full) begin
                word_d          = sr_q[full_idx];
                lane_d          = full_idx;
                valid_d         = 1'b1;
                sr_d[full_idx]  = '0;
                cnt_d[full_idx] = '0;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                sr_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            word_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                sr_q[i]  <= sr_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            word_q  <= word_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_word  = word_q;
    assign out_lane  = lane_q;
    assign out_valid = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_demux8_shift_collector.sv
// ---------------------------------------------------------------------------
// tb_demux8_shift_collector
//
// Directed self-checking bench for demux8_shift_collector (DEPTH = 8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that
// same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_demux8_shift_collector;

    logic       clk;
    logic       reset;
    logic       in_bit;
    logic       in_valid;
    logic       j2, j1, j0;
    logic       in_ready;
    logic [7:0] out_word;
    logic [2:0] out_lane;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    int compareCount;
    int mismatchCount;

    demux8_shift_collector #(.DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .j2        (j2),
        .j1        (j1),
        .j0        (j0),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_lane  (out_lane),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the lane select from a lane number (j2 = LSB, j0 = MSB).
    task automatic setLane(input logic [2:0] lane);
        j2 = lane[0];
        j1 = lane[1];
        j0 = lane[2];
    endtask

    // Shift a full word into one lane, MSB first, one accept per cycle.
    task automatic applyStimulus(input logic [2:0] lane, input logic [7:0] word);
        setLane(lane);
        for (int b = 7; b >= 0; b--) begin
            in_valid = 1'b1;
            in_bit   = word[b];
            step();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    logic [7:0] vec;

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reset     = 1'b1;
        in_bit    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        setLane(3'd0);

        // ---- Reset held two cycles with in_valid high ----
        step();
        step();
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_word",  32'(out_word),  32'd0);
        checkOutput("reset out_lane",  32'(out_lane),  32'd0);
        checkOutput("reset err",       32'(err),       32'd0);
        in_valid = 1'b0;
        reset    = 1'b0;
        for (int l = 0; l < 8; l++) begin
            setLane(3'(l));
            #1;
            checkOutput($sformatf("reset in_ready lane%0d", l), 32'(in_ready), 32'd1);
        end
        step();
        checkOutput("reset no fill", 32'(out_valid), 32'd0);

        // ---- Lane 0: 1,0,1,1,0,0,1,0 -> 0xB2 one cycle after 8th accept ----
        out_ready = 1'b1;
        applyStimulus(3'd0, 8'hB2);
        checkOutput("lane0 not yet valid", 32'(out_valid), 32'd0);
        step();
        checkOutput("lane0 out_valid", 32'(out_valid), 32'd1);
        checkOutput("lane0 out_word",  32'(out_word),  32'hB2);
        checkOutput("lane0 out_lane",  32'(out_lane),  32'd0);
        step();
        checkOutput("lane0 valid drops", 32'(out_valid), 32'd0);
        checkOutput("lane0 word holds",  32'(out_word),  32'hB2);

        // ---- Select mapping: j2 only, j1 only, j0 only ----
        j2 = 1'b1; j1 = 1'b0; j0 = 1'b0;
        applyStimulus({j0, j1, j2}, 8'h3C);
        step();
        checkOutput("map j2 lane", 32'(out_lane), 32'd1);
        checkOutput("map j2 word", 32'(out_word), 32'h3C);
        step();
        j2 = 1'b0; j1 = 1'b1; j0 = 1'b0;
        applyStimulus({j0, j1, j2}, 8'hA5);
        step();
        checkOutput("map j1 lane", 32'(out_lane), 32'd2);
        checkOutput("map j1 word", 32'(out_word), 32'hA5);
        step();
        j2 = 1'b0; j1 = 1'b0; j0 = 1'b1;
        applyStimulus({j0, j1, j2}, 8'h0F);
        step();
        checkOutput("map j0 lane", 32'(out_lane), 32'd4);
        checkOutput("map j0 word", 32'(out_word), 32'h0F);
        step();
        checkOutput("map idle", 32'(out_valid), 32'd0);

        // ---- Backpressure: lane 3 then lane 5 with out_ready low ----
        // Lane 3 moves into the empty output slot as lane 5 starts filling;
        // lane 5 then sits full behind it.
        out_ready = 1'b0;
        applyStimulus(3'd3, 8'hC3);
        applyStimulus(3'd5, 8'h96);
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("bp hold valid c%0d", c), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp hold lane c%0d", c),  32'(out_lane),  32'd3);
            checkOutput($sformatf("bp hold word c%0d", c),  32'(out_word),  32'hC3);
            step();
        end
        // Extra write into the still-full lane 5 is dropped and flags err.
        setLane(3'd5);
        in_bit = 1'b1;
        #1;
        checkOutput("bp full in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp err before", 32'(err), 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checkOutput("bp err set",     32'(err),      32'd1);
        checkOutput("bp word stable", 32'(out_word), 32'hC3);
        checkOutput("bp lane stable", 32'(out_lane), 32'd3);
        out_ready = 1'b1;
        step();
        checkOutput("bp lane5 valid", 32'(out_valid), 32'd1);
        checkOutput("bp lane5 lane",  32'(out_lane),  32'd5);
        checkOutput("bp lane5 word",  32'(out_word),  32'h96);
        step();
        checkOutput("bp drained", 32'(out_valid), 32'd0);
        checkOutput("bp err sticky", 32'(err), 32'd1);

        // ---- Interleave lane 2 (ones) with lane 6 (zeros) ----
        for (int k = 0; k < 16; k++) begin
            setLane((k % 2 == 0) ? 3'd2 : 3'd6);
            in_bit   = (k % 2 == 0);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        checkOutput("ilv lane2 valid", 32'(out_valid), 32'd1);
        checkOutput("ilv lane2 lane",  32'(out_lane),  32'd2);
        checkOutput("ilv lane2 word",  32'(out_word),  32'hFF);
        step();
        checkOutput("ilv lane6 valid", 32'(out_valid), 32'd1);
        checkOutput("ilv lane6 lane",  32'(out_lane),  32'd6);
        checkOutput("ilv lane6 word",  32'(out_word),  32'h00);
        step();
        checkOutput("ilv idle", 32'(out_valid), 32'd0);

        // ---- Reset mid-operation: partial lane 7 is discarded ----
        setLane(3'd7);
        for (int k = 0; k < 5; k++) begin
            in_bit   = 1'b1;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("mid reset err",   32'(err),       32'd0);
        checkOutput("mid reset valid", 32'(out_valid), 32'd0);
        checkOutput("mid reset word",  32'(out_word),  32'd0);
        vec = 8'h5A;
        applyStimulus(3'd7, vec);
        checkOutput("mid no early word", 32'(out_valid), 32'd0);
        step();
        checkOutput("mid lane7 valid", 32'(out_valid), 32'd1);
        checkOutput("mid lane7 lane",  32'(out_lane),  32'd7);
        checkOutput("mid lane7 word",  32'(out_word),  32'h5A);
        step();
        checkOutput("mid single word", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
